// File: rtl/dram_cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_cmd_scheduler_pkg
// Purpose  : Shared types and constants for the DRAM command scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package dram_cmd_scheduler_pkg;

    localparam int ADDR_W     = 33;
    localparam int OPC_W      = 2;
    localparam int ROW_W      = 15;
    localparam int COL_W      = 8;
    localparam int BANK_W     = 2;
    localparam int BG_W       = 2;
    localparam int BANK_IDX_W = BG_W + BANK_W;
    localparam int NUM_BANKS  = 1 << BANK_IDX_W;

    localparam int ROW_LSB    = 18;
    localparam int COL_LSB    = 10;
    localparam int BANK_LSB   = 8;
    localparam int BG_LSB     = 6;

    localparam int unsigned DEF_T_RCD     = 24;
    localparam int unsigned DEF_T_RP      = 24;
    localparam int unsigned DEF_T_CL      = 24;
    localparam int unsigned DEF_T_CWL     = 20;
    localparam int unsigned DEF_T_RAS     = 52;
    localparam int unsigned DEF_T_BURST   = 4;
    localparam int unsigned DEF_CLK_RATIO = 2;

    localparam logic [OPC_W-1:0] OPC_ILLEGAL = 2'd3;
    localparam logic [OPC_W-1:0] OPC_WRITE   = 2'd1;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_PRE = 3'd1,
        CMD_ACT = 3'd2,
        CMD_RD  = 3'd3,
        CMD_WR  = 3'd4
    } dram_cmd_type_t;

    typedef struct packed {
        dram_cmd_type_t     cmd_type;
        logic [BG_W-1:0]    bank_group;
        logic [BANK_W-1:0]  bank;
        logic [ROW_W-1:0]   row;
        logic [COL_W-1:0]   column;
    } dram_cmd_t;

    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [ADDR_W-1:0]  address;
        logic [63:0]        time_cpu;
    } parser_out_struct_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_PRE   = 3'd2,
        ST_ACT   = 3'd3,
        ST_COL   = 3'd4,
        ST_DATA  = 3'd5
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/dram_cmd_scheduler_bank_state_table.sv
`default_nettype none
// ============================================================================
// Module   : dram_cmd_scheduler_bank_state_table
// Purpose  : Per-bank open flag, open row and tRAS countdown with lookup/update ports.
// Revision : 1.0 - initial release
// ============================================================================
module dram_cmd_scheduler_bank_state_table
    import dram_cmd_scheduler_pkg::*;
#(
    parameter int unsigned TRAS_LOAD = 103,
    parameter int unsigned TRAS_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BANK_IDX_W-1:0] lookup_bank,
    output logic                  lookup_open,
    output logic [ROW_W-1:0]      lookup_row,
    output logic                  lookup_tras_zero,
    input  logic                  upd_en,
    input  logic [BANK_IDX_W-1:0] upd_bank,
    input  logic                  upd_open,
    input  logic [ROW_W-1:0]      upd_row,
    input  logic                  upd_load_tras
);

    logic [NUM_BANKS-1:0] w_open_vec;
    logic [NUM_BANKS-1:0] w_tras_zero_vec;
    logic [ROW_W-1:0]     w_row_arr [NUM_BANKS];

    genvar g;
    generate
        for (g = 0; g < NUM_BANKS; g++) begin : g_bank
            logic              r_open;
            logic [ROW_W-1:0]  r_row;
            logic [TRAS_W-1:0] r_tras;
            logic              w_sel;

            assign w_sel = (upd_bank == BANK_IDX_W'(g));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_open <= 1'b0;
                    r_row  <= '0;
                    r_tras <= '0;
                end else begin
                    if (upd_en && w_sel) begin
                        r_open <= upd_open;
                        if (upd_open) begin
                            r_row <= upd_row;
                        end
                    end
                    // Counters run every clock regardless of FSM state, saturating at zero.
                    if (upd_load_tras && w_sel) begin
                        r_tras <= TRAS_W'(TRAS_LOAD);
                    end else if (r_tras != '0) begin
                        r_tras <= r_tras - 1'b1;
                    end
                end
            end

            assign w_open_vec[g]      = r_open;
            assign w_tras_zero_vec[g] = (r_tras == '0);
            assign w_row_arr[g]       = r_row;
        end
    endgenerate

    assign lookup_open      = w_open_vec[lookup_bank];
    assign lookup_tras_zero = w_tras_zero_vec[lookup_bank];
    assign lookup_row       = w_row_arr[lookup_bank];

endmodule
`default_nettype wire

// File: rtl/dram_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dram_cmd_scheduler
// Purpose  : Single-request DDR4 PRE/ACT/RD/WR sequencer with per-bank timing.
//            Define CLOSED_PAGE_EN for closed-page policy (default open-page).
// Revision : 1.0 - initial release
// ============================================================================
module dram_cmd_scheduler
    import dram_cmd_scheduler_pkg::*;
#(
    parameter int unsigned T_RCD     = DEF_T_RCD,
    parameter int unsigned T_RP      = DEF_T_RP,
    parameter int unsigned T_CL      = DEF_T_CL,
    parameter int unsigned T_CWL     = DEF_T_CWL,
    parameter int unsigned T_RAS     = DEF_T_RAS,
    parameter int unsigned T_BURST   = DEF_T_BURST,
    parameter int unsigned CLK_RATIO = DEF_CLK_RATIO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  parser_out_struct_t in_req,
    output logic               in_ready,
    output logic               cmd_valid,
    output dram_cmd_t          cmd,
    output logic [63:0]        cmd_time,
    output logic               done,
    output logic               busy
);

    localparam int unsigned RCD_CYC     = T_RCD * CLK_RATIO;
    localparam int unsigned RP_CYC      = T_RP * CLK_RATIO;
    localparam int unsigned RAS_CYC     = T_RAS * CLK_RATIO;
    localparam int unsigned RD_DATA_CYC = (T_CL + T_BURST) * CLK_RATIO;
    localparam int unsigned WR_DATA_CYC = (T_CWL + T_BURST) * CLK_RATIO;
    localparam int unsigned TRAS_W      = $clog2(RAS_CYC + 1);

    sched_state_t          r_state, w_state_next;
    logic [63:0]           r_cycle;
    logic [63:0]           r_ready_time;
    logic [OPC_W-1:0]      r_opcode;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_pre_issued;
    dram_cmd_t             r_cmd_last;
    logic [63:0]           r_time_last;

    logic [ROW_W-1:0]      w_row;
    logic [COL_W-1:0]      w_col;
    logic [BANK_W-1:0]     w_bank;
    logic [BG_W-1:0]       w_bg;
    logic [BANK_IDX_W-1:0] w_bank_idx;
    logic                  w_cmd_slot;
    logic                  w_lk_open, w_lk_tras_zero;
    logic [ROW_W-1:0]      w_lk_row;
    logic                  w_issue, w_done;
    dram_cmd_type_t        w_issue_type;
    logic [63:0]           w_wait;
    logic                  w_upd_en, w_upd_open, w_upd_load_tras;
    dram_cmd_t             w_cmd_now;
    logic                  w_unused_bits;

    assign w_row      = r_addr[ROW_LSB +: ROW_W];
    assign w_col      = r_addr[COL_LSB +: COL_W];
    assign w_bank     = r_addr[BANK_LSB +: BANK_W];
    assign w_bg       = r_addr[BG_LSB +: BG_W];
    assign w_bank_idx = {w_bg, w_bank};

    // Commands only on DRAM edges, and never before the previous command's wait expires.
    assign w_cmd_slot = ((r_cycle % 64'(CLK_RATIO)) == 64'd0) && (r_cycle >= r_ready_time);

    assign w_unused_bits = ^{in_req.time_cpu, r_addr[BG_LSB-1:0]};

    dram_cmd_scheduler_bank_state_table #(
        .TRAS_LOAD (RAS_CYC - 1),
        .TRAS_W    (TRAS_W)
    ) u_bank_table (
        .clk              (clk),
        .rst              (rst),
        .lookup_bank      (w_bank_idx),
        .lookup_open      (w_lk_open),
        .lookup_row       (w_lk_row),
        .lookup_tras_zero (w_lk_tras_zero),
        .upd_en           (w_upd_en),
        .upd_bank         (w_bank_idx),
        .upd_open         (w_upd_open),
        .upd_row          (w_row),
        .upd_load_tras    (w_upd_load_tras)
    );

    always_comb begin
        w_state_next    = r_state;
        w_issue         = 1'b0;
        w_issue_type    = CMD_NOP;
        w_wait          = 64'd0;
        w_done          = 1'b0;
        w_upd_en        = 1'b0;
        w_upd_open      = 1'b0;
        w_upd_load_tras = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_opcode == OPC_ILLEGAL) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (!w_lk_open) begin
                    w_state_next = ST_ACT;
                end else if (w_lk_row == w_row) begin
                    w_state_next = ST_COL;
                end else begin
                    w_state_next = ST_PRE;
                end
            end
            ST_PRE: begin
                if (r_pre_issued) begin
                    if (r_cycle >= r_ready_time) begin
                        w_state_next = ST_IDLE;
                    end
                end else if (w_cmd_slot && w_lk_tras_zero) begin
                    w_issue      = 1'b1;
                    w_issue_type = CMD_PRE;
                    w_wait       = 64'(RP_CYC);
                    w_upd_en     = 1'b1;
`ifdef CLOSED_PAGE_EN
                    w_state_next = ST_PRE;
`else
                    w_state_next = ST_ACT;
`endif
                end
            end
            ST_ACT: begin
                if (w_cmd_slot) begin
                    w_issue         = 1'b1;
                    w_issue_type    = CMD_ACT;
                    w_wait          = 64'(RCD_CYC);
                    w_upd_en        = 1'b1;
                    w_upd_open      = 1'b1;
                    w_upd_load_tras = 1'b1;
                    w_state_next    = ST_COL;
                end
            end
            ST_COL: begin
                if (w_cmd_slot) begin
                    w_issue      = 1'b1;
                    w_issue_type = (r_opcode == OPC_WRITE) ? CMD_WR : CMD_RD;
                    w_wait       = (r_opcode == OPC_WRITE) ? 64'(WR_DATA_CYC) : 64'(RD_DATA_CYC);
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cycle >= r_ready_time) begin
                    w_done       = 1'b1;
`ifdef CLOSED_PAGE_EN
                    w_state_next = ST_PRE;
`else
                    w_state_next = ST_IDLE;
`endif
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_now            = '0;
        w_cmd_now.cmd_type   = w_issue_type;
        w_cmd_now.bank_group = w_bg;
        w_cmd_now.bank       = w_bank;
        w_cmd_now.row        = w_row;
        w_cmd_now.column     = w_col;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cycle      <= 64'd0;
            r_ready_time <= 64'd0;
            r_opcode     <= '0;
            r_addr       <= '0;
            r_pre_issued <= 1'b0;
            r_cmd_last   <= '0;
            r_time_last  <= 64'd0;
        end else begin
            r_state      <= w_state_next;
            r_cycle      <= r_cycle + 64'd1;
            r_pre_issued <= (w_state_next == ST_PRE) &&
                            (r_pre_issued || (w_issue && (w_issue_type == CMD_PRE)));
            if (in_valid && in_ready) begin
                r_opcode <= in_req.opcode;
                r_addr   <= in_req.address;
            end
            if (w_issue) begin
                r_ready_time <= r_cycle + w_wait;
                r_cmd_last   <= w_cmd_now;
                r_time_last  <= r_cycle;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign cmd_valid = w_issue;
    assign cmd       = w_issue ? w_cmd_now : r_cmd_last;
    assign cmd_time  = w_issue ? r_cycle : r_time_last;
    assign done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_dram_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_cmd_scheduler
// Purpose  : Scoreboard bench for dram_cmd_scheduler with a timing reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_cmd_scheduler;
    import dram_cmd_scheduler_pkg::*;

    localparam longint R      = DEF_CLK_RATIO;
    localparam longint RCD    = DEF_T_RCD * R;
    localparam longint RP     = DEF_T_RP * R;
    localparam longint RAS    = DEF_T_RAS * R;
    localparam longint RD_DAT = (DEF_T_CL + DEF_T_BURST) * R;
    localparam longint WR_DAT = (DEF_T_CWL + DEF_T_BURST) * R;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    parser_out_struct_t in_req = '0;
    logic               in_ready, cmd_valid, done, busy;
    dram_cmd_t          cmd;
    logic [63:0]        cmd_time;

    dram_cmd_scheduler dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_req(in_req),
        .in_ready(in_ready), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_time(cmd_time), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    longint cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        dram_cmd_type_t ty;
        logic [1:0]     bg;
        logic [1:0]     bk;
        logic [14:0]    row;
        logic [7:0]     col;
        longint         t;
    } exp_t;

    exp_t   exp_q[$];
    longint done_q[$];
    int     total = 0;
    int     bad = 0;

    // Reference model: bank status plus the cycle the scheduler next becomes idle.
    bit          m_open [16];
    logic [14:0] m_row  [16];
    longint      m_act  [16];
    longint      m_idle;

    function automatic longint align(longint t);
        return t + ((R - (t % R)) % R);
    endfunction

    function automatic longint lmax(longint a, longint b);
        return (a > b) ? a : b;
    endfunction

    function automatic void push_cmd(dram_cmd_type_t ty, logic [32:0] a, longint t);
        exp_t e;
        e.ty = ty; e.bg = a[7:6]; e.bk = a[9:8]; e.row = a[32:18]; e.col = a[17:10]; e.t = t;
        exp_q.push_back(e);
    endfunction

    function automatic void model(longint acc, logic [1:0] op, logic [32:0] a);
        int     idx;
        longint t, pre_t, act_t, col_t, done_t;
        idx = {a[7:6], a[9:8]};
        if (op == 2'd3) begin
            done_q.push_back(acc + 1);
            m_idle = acc + 2;
            return;
        end
        t = acc + 2;
        if (m_open[idx] && m_row[idx] == a[32:18]) begin
            col_t = align(t);
        end else begin
            if (m_open[idx]) begin
                pre_t = align(lmax(t, m_act[idx] + RAS));
                push_cmd(CMD_PRE, a, pre_t);
                t = pre_t + RP;
            end
            act_t = align(t);
            push_cmd(CMD_ACT, a, act_t);
            m_act[idx]  = act_t;
            m_open[idx] = 1'b1;
            m_row[idx]  = a[32:18];
            col_t = act_t + RCD;
        end
        push_cmd((op == 2'd1) ? CMD_WR : CMD_RD, a, col_t);
        done_t = col_t + ((op == 2'd1) ? WR_DAT : RD_DAT);
        done_q.push_back(done_t);
`ifdef CLOSED_PAGE_EN
        pre_t = align(lmax(done_t + 1, m_act[idx] + RAS));
        push_cmd(CMD_PRE, a, pre_t);
        m_open[idx] = 1'b0;
        m_idle = pre_t + RP + 1;
`else
        m_idle = done_t + 1;
`endif
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a command or done pulse.
    exp_t   mon_e;
    longint mon_t;
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL cmd_unexpected: got type=%0d t=%0d, none expected", cmd.cmd_type, cmd_time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (cmd.cmd_type !== mon_e.ty || cmd.bank_group !== mon_e.bg || cmd.bank !== mon_e.bk ||
                        (mon_e.ty != CMD_PRE && cmd.row !== mon_e.row) ||
                        ((mon_e.ty == CMD_RD || mon_e.ty == CMD_WR) && cmd.column !== mon_e.col) ||
                        cmd_time !== 64'(mon_e.t) || cyc != mon_e.t) begin
                        bad++;
                        $display("FAIL cmd: got type=%0d bg=%0d bk=%0d row=%0d col=%0d t=%0d cyc=%0d, want type=%0d bg=%0d bk=%0d row=%0d col=%0d t=%0d",
                                 cmd.cmd_type, cmd.bank_group, cmd.bank, cmd.row, cmd.column, cmd_time, cyc,
                                 mon_e.ty, mon_e.bg, mon_e.bk, mon_e.row, mon_e.col, mon_e.t);
                    end
                end
            end
            if (done) begin
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected: got done at %0d, none expected", cyc);
                end else begin
                    mon_t = done_q.pop_front();
                    if (cyc != mon_t) begin
                        bad++;
                        $display("FAIL done: got at %0d, want %0d", cyc, mon_t);
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                total++; bad++;
                $display("FAIL cmd_missing: got nothing, want type=%0d at %0d", exp_q[0].ty, exp_q[0].t);
                void'(exp_q.pop_front());
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                total++; bad++;
                $display("FAIL done_missing: got nothing, want done at %0d", done_q[0]);
                void'(done_q.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || cmd_valid !== 1'b0 || done !== 1'b0 ||
            cmd !== '0 || cmd_time !== 64'd0) begin
            bad++;
            $display("FAIL %s: got rdy=%b busy=%b cv=%b done=%b cmd=%h t=%0d, want 1 0 0 0 0 0",
                     name, in_ready, busy, cmd_valid, done, cmd, cmd_time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        exp_q.delete();
        done_q.delete();
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_async");
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0;
            m_act[i]  = 0;
        end
        m_idle = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [32:0] a, input int gap);
        longint pred;
        int     n;
        repeat (gap) @(negedge clk);
        in_valid        = 1'b1;
        in_req.opcode   = op;
        in_req.address  = a;
        in_req.time_cpu = 64'(cyc);
        pred = lmax(cyc, m_idle);
        n = 0;
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1 || cyc != pred || busy !== 1'b0) begin
            bad++;
            $display("FAIL accept: got cyc=%0d rdy=%b busy=%b, want cyc=%0d rdy=1 busy=0", cyc, in_ready, busy, pred);
        end
        if (in_ready === 1'b1) begin
            model(cyc, op, a);
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL handshake_drop: got rdy=%b busy=%b, want rdy=0 busy=1", in_ready, busy);
            end
        end
        in_valid = 1'b0;
    endtask

    localparam logic [32:0] A_ROW1 = 33'h0_0004_0000;
    localparam logic [32:0] A_ROW2 = 33'h0_0008_0000;
    localparam logic [32:0] A_B5R1 = 33'h0_0004_0140;
    localparam logic [32:0] A_B5R3 = 33'h0_000C_0140;

    initial begin
        int          n;
        int          sel;
        logic [1:0]  op;
        logic [32:0] a;

        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0;
            m_act[i]  = 0;
        end
        m_idle = 0;
        @(negedge clk);
        check_reset_outputs("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        repeat (20) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1 || cmd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle: got rdy=%b cv=%b done=%b busy=%b, want 1 0 0 0", in_ready, cmd_valid, done, busy);
            end
        end

        // Closed bank, then hit with write, then row miss on the same bank.
        do_reset();
        while (cyc < 10) @(negedge clk);
        send(2'd0, A_ROW1, 0);
        send(2'd1, A_ROW1, 0);
        send(2'd0, A_ROW2, 0);

        // Write opens a row then an early miss must hold PRE for tRAS.
        do_reset();
        while (cyc < 10) @(negedge clk);
        send(2'd1, A_ROW1, 0);
        send(2'd2, A_ROW2, 0);
        send(2'd3, A_ROW2, 1);

        // Reset between ACT and RD: next access to that bank sees it closed.
        do_reset();
        send(2'd0, A_B5R1, 2);
        n = 0;
        while (exp_q.size() > 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        do_reset();
        send(2'd0, A_B5R3, 1);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            op  = (sel < 4) ? 2'd0 : (sel < 8) ? 2'd1 : (sel == 8) ? 2'd2 : 2'd3;
            a   = {15'($urandom_range(0, 3)), 8'($urandom), 2'($urandom_range(0, 1)),
                   2'($urandom_range(0, 1)), 6'($urandom)};
            send(op, a, $urandom_range(0, 3));
        end

        n = 0;
        while ((exp_q.size() > 0 || done_q.size() > 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d cmds %0d dones outstanding, want 0 0", exp_q.size(), done_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Downstream consumer of the memory request queue; takes one request at a time and decodes its address into bank group, bank, row and column.
- Tracks the open row of each of the 16 banks and issues the DDR4 command sequence (PRE/ACT/RD/WR) with DRAM timing enforced.
- Emits a timestamped command stream for the output trace writer; open-page policy by default.

Parameters:
- T_RCD, 24, ACT to RD/WR, in DRAM cycles
- T_RP, 24, PRE to ACT, in DRAM cycles
- T_CL, 24, RD to data complete, in DRAM cycles (excludes burst)
- T_CWL, 20, WR to data complete, in DRAM cycles (excludes burst)
- T_RAS, 52, ACT to PRE on the same bank, in DRAM cycles
- T_BURST, 4, burst length, in DRAM cycles
- CLK_RATIO, 2, CPU clocks per DRAM clock

Ports:
- clk  in  1  CPU clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  queue head holds a request
- in_req  in  $bits(parser_out_struct_t)  request: opcode, address, time_cpu
- in_ready  out  1  scheduler can accept a request
- cmd_valid  out  1  one-clock pulse, command issued this cycle
- cmd  out  $bits(dram_cmd_t)  issued command: type, bank_group, bank, row, column
- cmd_time  out  64  CPU cycle of the issued command
- done  out  1  one-clock pulse, request data phase complete
- busy  out  1  FSM not IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: in_ready=1, cmd_valid=0, cmd=0, cmd_time=0, done=0, busy=0, cycle counter=0, all banks closed, all tRAS counters=0, FSM=IDLE.
- Reset mid-operation: abandons the request immediately; no PRE is issued for banks that were open.
- Cycle counter: 64-bit, increments every clk. A command issues only on a DRAM edge, defined as counter % CLK_RATIO == 0. All timing waits are value*CLK_RATIO CPU clocks.
- Address decode (33-bit):
  - row = addr[32:18]
  - column = addr[17:10]
  - bank = addr[9:8]
  - bank_group = addr[7:6]
  - addr[5:0] ignored
  - Bank index = {bank_group, bank}.
- Opcodes: 0 and 2 map to RD; 1 maps to WR; 3 is illegal. An illegal opcode is accepted, no command is issued, and done pulses the next cycle.
- Handshake:
  - in_ready=1 only in IDLE.
  - A request is accepted on a clock with in_valid && in_ready; in_req is latched that cycle and the FSM leaves IDLE on the same edge.
  - in_ready drops the following cycle.
- FSM states: IDLE, CHECK, PRE, ACT, COL, DATA.
  - CHECK (one clock) classifies the request:
    - bank open, same row (hit) -> COL
    - bank closed -> ACT
    - bank open, different row (miss) -> PRE
  - PRE: issue PRE on the first DRAM edge where the bank's tRAS counter is 0; mark the bank closed; wait T_RP*CLK_RATIO; -> ACT.
  - ACT: issue ACT on the first DRAM edge; record the open row; load the bank's tRAS counter with T_RAS*CLK_RATIO; wait T_RCD*CLK_RATIO; -> COL.
  - COL: issue RD or WR on the first DRAM edge; -> DATA.
  - DATA: wait (T_CL or T_CWL + T_BURST)*CLK_RATIO; pulse done; -> IDLE.
- Waits are measured from the command's issue cycle; the next command issues exactly at issue_cycle + wait, which always falls on a DRAM edge.
- tRAS counters:
  - 16 counters, one per bank, saturating at 0.
  - All decrement every clk, independent of FSM state.
- Outputs:
  - cmd_time equals the counter value on the cycle cmd_valid is high.
  - cmd retains its last value when cmd_valid=0.

Optional Feature:
- Macro: CLOSED_PAGE_EN.
- Defined: after DATA the FSM enters PRE for the same bank, issuing PRE once tRAS is satisfied, then waits T_RP*CLK_RATIO before IDLE. done pulses at the end of DATA, as in open-page mode. CHECK never sees an open bank.
- Undefined: open-page policy; rows stay open until a miss.

Decomposition:
- global_defs gains:
  - dram_cmd_type_t enum: NOP, PRE, ACT, RD, WR
  - dram_cmd_t packed struct
  - address field width localparams
  - timing default constants
- Natural sub-module: bank_state_table, holding the per-bank open flag, open row and tRAS counter, with a lookup port and an update port.

Test Plan:
- Reset, then idle 20 clocks -> in_ready=1; cmd_valid, done and busy stay 0; all banks closed.
- RD, address 0x0_0004_0000, accepted at cycle 10 -> ACT @12 (row 1, bg 0, bank 0), RD @60, done @116.
- Same address, opcode 1, accepted immediately after -> no ACT; WR at first even cycle ≥ accept+2; done 48 clocks after WR.
- Miss: same bank, row 2, accepted at cycle 120 when ACT was @12 -> PRE @122 (tRAS met), ACT @170, RD @218.
- Miss issued early, ACT @12 and accept @20 -> PRE held until cycle 116 (12+104).
- rst pulsed mid-wait between ACT and RD -> outputs return to reset values asynchronously; next request to the same bank takes the closed-bank path (ACT, no PRE).
